// File: rtl/tmds_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_decoder_pkg
//  Description : Control-token constants, alignment FSM states and token
//                lookup shared by the TMDS decoder and its symbol decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package tmds_decoder_pkg;

    localparam logic [9:0] c_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] c_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] c_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] c_CTRL_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } align_state_e;

    // Returns {is_ctrl, c1, c0}; c is 00 when the symbol is not a token.
    function automatic logic [2:0] tmds_ctrl_lookup(input logic [9:0] sym);
        logic [2:0] result;
        case (sym)
            c_CTRL_00: result = 3'b100;
            c_CTRL_01: result = 3'b101;
            c_CTRL_10: result = 3'b110;
            c_CTRL_11: result = 3'b111;
            default:   result = 3'b000;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_symbol_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_symbol_decode
//  Description : Combinational map of one 10-bit TMDS symbol to {de, c, data}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tmds_symbol_decode
    import tmds_decoder_pkg::*;
(
    input  logic [9:0] i_symbol,
    output logic       o_de,
    output logic [1:0] o_c,
    output logic [7:0] o_data
);

    logic [2:0] w_ctrl;
    logic [7:0] w_d;
    logic [6:0] w_x;

    always_comb begin
        w_ctrl = tmds_ctrl_lookup(i_symbol);
        w_d    = i_symbol[9] ? ~i_symbol[7:0] : i_symbol[7:0];
        // Bit 8 selects whether the encoder used an XOR or XNOR chain.
        w_x    = w_d[7:1] ^ w_d[6:0];
        o_de   = ~w_ctrl[2];
        o_c    = w_ctrl[2] ? w_ctrl[1:0] : 2'b00;
        o_data = w_ctrl[2] ? 8'h00
                           : {(i_symbol[8] ? w_x : ~w_x), w_d[0]};
    end

endmodule
`default_nettype wire

// File: rtl/tmds_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_decoder
//  Description : Two-stage TMDS symbol decoder with word-alignment FSM that
//                hunts for control tokens and requests bitslips.
//  Revision    : 1.0 - initial release
// ============================================================================
module tmds_decoder
    import tmds_decoder_pkg::*;
#(
    parameter int SEARCH_WINDOW = 2048,
    parameter int LOCK_COUNT    = 16,
    parameter int SLIP_SETTLE   = 16,
    parameter int LOSS_WINDOW   = 1048576
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] tmds_in,
    input  logic       valid_in,
    output logic [7:0] data_out,
    output logic [1:0] c_out,
    output logic       de_out,
    output logic       valid_out,
    output logic       locked_out,
    output logic       bitslip_out
);

    localparam int c_SEARCH_W = $clog2(SEARCH_WINDOW + 1);
    localparam int c_LOCK_W   = $clog2(LOCK_COUNT + 1);
    localparam int c_SETTLE_W = $clog2(SLIP_SETTLE + 1);
    localparam int c_LOSS_W   = $clog2(LOSS_WINDOW + 1);

    localparam logic [c_SEARCH_W-1:0] c_SEARCH_MAX = c_SEARCH_W'(SEARCH_WINDOW);
    localparam logic [c_LOCK_W-1:0]   c_LOCK_MAX   = c_LOCK_W'(LOCK_COUNT);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_MAX = c_SETTLE_W'(SLIP_SETTLE);
    localparam logic [c_LOSS_W-1:0]   c_LOSS_MAX   = c_LOSS_W'(LOSS_WINDOW);

    logic       w_dec_de;
    logic [1:0] w_dec_c;
    logic [7:0] w_dec_data;

    tmds_symbol_decode u_decode (
        .i_symbol (tmds_in),
        .o_de     (w_dec_de),
        .o_c      (w_dec_c),
        .o_data   (w_dec_data)
    );

    // ------------------------------------------------------------------
    // Decode pipeline: stage 1 captures the decoded symbol, stage 2 drives
    // the outputs and holds them across invalid cycles.
    // ------------------------------------------------------------------
    logic       r_s1_valid;
    logic       r_s1_de;
    logic [1:0] r_s1_c;
    logic [7:0] r_s1_data;
    logic       r_valid;
    logic       r_de;
    logic [1:0] r_c;
    logic [7:0] r_data;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_s1_valid <= 1'b0;
            r_s1_de    <= 1'b0;
            r_s1_c     <= 2'b00;
            r_s1_data  <= 8'h00;
            r_valid    <= 1'b0;
            r_de       <= 1'b0;
            r_c        <= 2'b00;
            r_data     <= 8'h00;
        end else begin
            r_s1_valid <= valid_in;
            r_s1_de    <= w_dec_de;
            r_s1_c     <= w_dec_c;
            r_s1_data  <= w_dec_data;
            r_valid    <= r_s1_valid;
            if (r_s1_valid) begin
                r_data <= r_s1_data;
                r_de   <= r_s1_de;
                // Data periods keep the last control value on c_out.
                if (!r_s1_de) begin
                    r_c <= r_s1_c;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Alignment FSM
    // ------------------------------------------------------------------
    align_state_e          r_state,      w_state_nx;
    logic [c_SEARCH_W-1:0] r_search_cnt, w_search_nx;
    logic [c_LOCK_W-1:0]   r_run_cnt,    w_run_nx;
    logic [c_SETTLE_W-1:0] r_settle_cnt, w_settle_nx;
    logic [c_LOSS_W-1:0]   r_loss_cnt,   w_loss_nx;
    logic [1:0]            r_last_c,     w_last_c_nx;
    logic                  r_slip,       w_slip_nx;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= ST_SEARCH;
            r_search_cnt <= '0;
            r_run_cnt    <= '0;
            r_settle_cnt <= '0;
            r_loss_cnt   <= '0;
            r_last_c     <= 2'b00;
            r_slip       <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_search_cnt <= w_search_nx;
            r_run_cnt    <= w_run_nx;
            r_settle_cnt <= w_settle_nx;
            r_loss_cnt   <= w_loss_nx;
            r_last_c     <= w_last_c_nx;
            r_slip       <= w_slip_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_search_nx = r_search_cnt;
        w_run_nx    = r_run_cnt;
        w_settle_nx = r_settle_cnt;
        w_loss_nx   = r_loss_cnt;
        w_last_c_nx = r_last_c;
        w_slip_nx   = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (valid_in) begin
                    if (!w_dec_de) begin
                        w_search_nx = '0;
                        w_last_c_nx = w_dec_c;
                        // A non-zero run means the previous symbol was a token.
                        if (r_run_cnt != '0 && w_dec_c == r_last_c) begin
                            w_run_nx = r_run_cnt + 1'b1;
                        end else begin
                            w_run_nx = c_LOCK_W'(1);
                        end
                        if (w_run_nx == c_LOCK_MAX) begin
                            w_state_nx = ST_LOCKED;
                            w_run_nx   = '0;
                            w_loss_nx  = '0;
                        end
                    end else begin
                        w_run_nx    = '0;
                        w_search_nx = r_search_cnt + 1'b1;
                        if (w_search_nx == c_SEARCH_MAX) begin
                            w_slip_nx   = 1'b1;
                            w_search_nx = '0;
                            w_settle_nx = '0;
                            w_state_nx  = ST_SETTLE;
                        end
                    end
                end
            end
            ST_SETTLE: begin
                w_settle_nx = r_settle_cnt + 1'b1;
                if (w_settle_nx == c_SETTLE_MAX) begin
                    w_state_nx  = ST_SEARCH;
                    w_settle_nx = '0;
                    w_search_nx = '0;
                    w_run_nx    = '0;
                end
            end
            ST_LOCKED: begin
                if (valid_in) begin
                    if (!w_dec_de) begin
                        w_loss_nx = '0;
                    end else begin
                        w_loss_nx = r_loss_cnt + 1'b1;
                        if (w_loss_nx == c_LOSS_MAX) begin
                            w_state_nx  = ST_SEARCH;
                            w_loss_nx   = '0;
                            w_search_nx = '0;
                            w_run_nx    = '0;
                        end
                    end
                end
            end
            default: begin
                w_state_nx = ST_SEARCH;
            end
        endcase
    end

    assign data_out    = r_data;
    assign c_out       = r_c;
    assign de_out      = r_de;
    assign valid_out   = r_valid;
    assign locked_out  = (r_state == ST_LOCKED);
    assign bitslip_out = r_slip;

endmodule
`default_nettype wire

// File: doc/tmds_decoder.md
TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 Parameter SEARCH_WINDOW, default 2048: symbols without a control token before a bitslip is requested.
REQ-002 Parameter LOCK_COUNT, default 16: consecutive identical control tokens needed to declare lock.
REQ-003 Parameter SLIP_SETTLE, default 16: cycles ignored after a bitslip request.
REQ-004 Parameter LOSS_WINDOW, default 1048576: symbols without any control token before lock is dropped.
REQ-005 clk_in  input  1  pixel clock; all logic is on the rising edge.
REQ-006 rst_in  input  1  reset, synchronous, active-high.
REQ-007 tmds_in  input  10  received symbol from the deserializer; bit 0 is the first bit on the wire.
REQ-008 valid_in  input  1  tmds_in is valid this cycle.
REQ-009 data_out  output  8  decoded pixel byte.
REQ-010 c_out  output  2  decoded control bits {c1,c0}.
REQ-011 de_out  output  1  1 = data period, 0 = control token.
REQ-012 valid_out  output  1  outputs are valid this cycle.
REQ-013 locked_out  output  1  word alignment is established.
REQ-014 bitslip_out  output  1  one-cycle request to the deserializer to shift alignment by one bit.

Function
REQ-015 Latency shall be fixed at 2 cycles from valid_in to valid_out, with no bubbles inserted; valid_out shall mirror valid_in delayed by 2.
REQ-016 Control tokens shall be matched as follows; on a match de_out=0, data_out=8'h00, and c_out is set from the token:
- 10'b1101010100 -> c_out=00
- 10'b0010101011 -> c_out=01
- 10'b0101010100 -> c_out=10
- 10'b1010101011 -> c_out=11
REQ-017 Any other symbol shall be decoded as data with de_out=1, c_out held at its last control value:
- Inversion: d' = tmds_in[9] ? ~tmds_in[7:0] : tmds_in[7:0].
- Chain: data_out[0] = d'[0].
- For i = 1..7: data_out[i] = d'[i]^d'[i-1] when tmds_in[8]=1, else ~(d'[i]^d'[i-1]).
REQ-018 The alignment FSM shall have states SEARCH, SETTLE and LOCKED, and shall advance only on valid_in cycles except for the SETTLE count.
REQ-019 SEARCH behaviour:
- Count symbols since the last control token.
- When the count reaches SEARCH_WINDOW: pulse bitslip_out for 1 cycle, clear the counters, go to SETTLE.
- When LOCK_COUNT consecutive identical control tokens are seen: go to LOCKED.
- A differing token restarts the run at 1; a data symbol restarts it at 0.
REQ-020 SETTLE shall count SLIP_SETTLE clock cycles regardless of valid_in, then return to SEARCH with all counters cleared.
REQ-021 LOCKED behaviour:
- locked_out=1.
- Any control token clears the loss counter.
- When the loss counter reaches LOSS_WINDOW: drop to SEARCH, locked_out=0 on the next cycle, no bitslip is issued.
REQ-022 Decoding shall be performed in every state; locked_out is advisory only and does not gate valid_out.
REQ-023 bitslip_out shall never be asserted on two cycles closer together than SLIP_SETTLE+1.
REQ-024 All counters shall saturate or clear on the cycle they reach their threshold and shall never wrap.

Reset
REQ-025 While rst_in=1 on a clock edge, the following shall hold from the next cycle:
- FSM state = SEARCH; all counters = 0.
- data_out=8'h00, c_out=2'b00, de_out=0, valid_out=0, locked_out=0, bitslip_out=0.
- Both pipeline valid stages are cleared.
REQ-026 Reset asserted mid-SETTLE or while LOCKED shall take effect on the next cycle with no residual bitslip pulse.

Structure
REQ-027 A shared package shall hold:
- the four control-token constants;
- the FSM state enum;
- a function mapping a 10-bit symbol to {is_ctrl, c[1:0]}.
REQ-028 One combinational sub-module, tmds_symbol_decode, shall map tmds_in to {de, c, data}; the pipeline registers and the FSM live in tmds_decoder.

Verification
REQ-029 Data decode cases, each with valid_in=1:
- tmds_in=10'b0100000000 -> 2 cycles later data_out=8'h00, de_out=1, valid_out=1.
- tmds_in=10'h2FF -> data_out=8'hFE, de_out=1.
REQ-030 16 consecutive 10'b1101010100 from reset -> locked_out=1 after the 16th token; c_out=00, de_out=0 throughout.
REQ-031 With SEARCH_WINDOW set to 8, feed 8 data symbols -> exactly one bitslip_out pulse, then none for 16 cycles, then search resumes.
REQ-032 Locked, then LOSS_WINDOW (set to 32) data symbols with no control token -> locked_out falls and bitslip_out stays 0.
REQ-033 Assert rst_in during SETTLE -> next cycle all outputs are 0 and the state is SEARCH; a loopback of every byte 0x00..0xFF through a reference encoder decodes back to the original byte.
